// File: rtl/fu_sched_pkg.sv
// fu_sched_pkg: shared types, constants and unit-index mapping for the issue scoreboard.
//   NUM_REGS/NUM_FU/REG_W  architectural register count, unit count, register index width
//   scalar_fu_t            decode-side unit encoding
//   slot_state_t           per-unit slot FSM state
//   FU_*                   functional unit indices (also the write-back priority order, LSU highest)
//   fu_index()             maps scalar_fu_t to the unit index
package fu_sched_pkg;
    localparam int NUM_REGS = 32;
    localparam int NUM_FU = 4;
    localparam int REG_W = $clog2(NUM_REGS);
    typedef enum logic [1:0] {
        SFU_ALU = 2'd0,
        SFU_LSU = 2'd1,
        SFU_MUL = 2'd2,
        SFU_DIV = 2'd3
    } scalar_fu_t;
    typedef enum logic [1:0] {IDLE, BUSY, WAIT} slot_state_t;
    localparam logic [1:0] FU_ARITH = 2'd0;
    localparam logic [1:0] FU_MUL = 2'd1;
    localparam logic [1:0] FU_DIV = 2'd2;
    localparam logic [1:0] FU_LSU = 2'd3;
    function automatic logic [1:0] fu_index(scalar_fu_t t);
        return t == SFU_LSU ? FU_LSU : t == SFU_MUL ? FU_MUL : t == SFU_DIV ? FU_DIV : FU_ARITH;
    endfunction
endpackage

// File: rtl/fu_issue_scoreboard_if.sv
// fu_issue_scoreboard_if: decode/unit-side bundle of the issue scoreboard.
//   master: drives issue_valid, sfu_type, reg_rs1/rs2/rd, wen, flush, fu_done;
//           receives issue_ready, fu_start, wb_valid, wb_grant, wb_rd
//   slave:  the scoreboard side, opposite directions
interface fu_issue_scoreboard_if;
    import fu_sched_pkg::*;
    logic              issue_valid;
    scalar_fu_t        sfu_type;
    logic [REG_W-1:0]  reg_rs1;
    logic [REG_W-1:0]  reg_rs2;
    logic [REG_W-1:0]  reg_rd;
    logic              wen;
    logic              flush;
    logic              issue_ready;
    logic [NUM_FU-1:0] fu_start;
    logic [NUM_FU-1:0] fu_done;
    logic              wb_valid;
    logic [NUM_FU-1:0] wb_grant;
    logic [REG_W-1:0]  wb_rd;
    modport master (
        output issue_valid, sfu_type, reg_rs1, reg_rs2, reg_rd, wen, flush, fu_done,
        input  issue_ready, fu_start, wb_valid, wb_grant, wb_rd
    );
    modport slave (
        input  issue_valid, sfu_type, reg_rs1, reg_rs2, reg_rd, wen, flush, fu_done,
        output issue_ready, fu_start, wb_valid, wb_grant, wb_rd
    );
endinterface

// File: rtl/fu_issue_scoreboard_slot.sv
// fu_slot: one in-flight operation tracker per functional unit (IDLE -> BUSY -> WAIT -> IDLE).
//   CLK, nRST   clock, asynchronous active-low reset
//   i_start     issue pulse for this unit; latches i_rd / i_wen
//   i_done      unit result valid; only honoured in BUSY
//   i_grant     write port granted to this slot
//   o_idle      slot can accept a new operation
//   o_req_wb    slot holds a result waiting for the write port
//   o_rd        latched destination register
module fu_slot
    import fu_sched_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_start,
    input  logic             i_wen,
    input  logic             i_done,
    input  logic             i_grant,
    input  logic [REG_W-1:0] i_rd,
    output logic             o_idle,
    output logic             o_req_wb,
    output logic [REG_W-1:0] o_rd
);
    slot_state_t      r_state;
    logic [REG_W-1:0] r_rd;
    logic             r_wen;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_rd <= '0;
            r_wen <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_state <= BUSY;
                    r_rd <= i_rd;
                    r_wen <= i_wen && i_rd != '0;
                end
                // results with no register destination never compete for the write port
                BUSY: if (i_done) r_state <= r_wen ? WAIT : IDLE;
                WAIT: if (i_grant) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_idle = r_state == IDLE;
    assign o_req_wb = r_state == WAIT;
    assign o_rd = r_rd;
endmodule

// File: rtl/fu_issue_scoreboard.sv
// fu_issue_scoreboard: hazard-checking issue control plus register-file write-port arbitration.
//   CLK, nRST  clock, asynchronous active-low reset
//   bus        slave side of fu_issue_scoreboard_if (issue request/accept, unit start/done,
//              write-back grant and destination)
module fu_issue_scoreboard
    import fu_sched_pkg::*;
(
    input  logic                  CLK,
    input  logic                  nRST,
    fu_issue_scoreboard_if.slave  bus
);
    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_pend_eff;
    logic [NUM_FU-1:0]   w_idle;
    logic [NUM_FU-1:0]   w_req;
    logic [NUM_FU-1:0]   w_grant;
    logic [REG_W-1:0]    w_slot_rd [NUM_FU];
    logic [REG_W-1:0]    w_wb_rd;
    logic [1:0]          w_idx;
    logic                w_wen;
    logic                w_hazard;
    logic                w_ready;
    for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
        fu_slot u_slot (
            .CLK      (CLK),
            .nRST     (nRST),
            .i_start  (bus.fu_start[i]),
            .i_wen    (bus.wen),
            .i_done   (bus.fu_done[i]),
            .i_grant  (w_grant[i]),
            .i_rd     (bus.reg_rd),
            .o_idle   (w_idle[i]),
            .o_req_wb (w_req[i]),
            .o_rd     (w_slot_rd[i])
        );
    end
    // highest unit index wins: LSU > DIV > MUL > ARITH
    always_comb begin
        w_grant = '0;
        w_wb_rd = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_req[i]) begin
                w_grant = NUM_FU'(1) << i;
                w_wb_rd = w_slot_rd[i];
            end
        end
    end
    assign bus.wb_valid = |w_req;
    assign bus.wb_grant = w_grant;
    assign bus.wb_rd = w_wb_rd;
    // register file is write-through, so the register written this cycle is already readable
    assign w_clr = bus.wb_valid ? NUM_REGS'(1) << w_wb_rd : '0;
    assign w_pend_eff = r_pend & ~w_clr;
    assign w_idx = fu_index(bus.sfu_type);
    assign w_wen = bus.wen && bus.reg_rd != '0;
    assign w_hazard = w_pend_eff[bus.reg_rs1] | w_pend_eff[bus.reg_rs2] | (bus.wen & w_pend_eff[bus.reg_rd]);
    assign w_ready = nRST & bus.issue_valid & ~bus.flush & w_idle[w_idx] & ~w_hazard;
    assign bus.issue_ready = w_ready;
    assign bus.fu_start = w_ready ? NUM_FU'(1) << w_idx : '0;
    assign w_set = w_ready && w_wen ? NUM_REGS'(1) << bus.reg_rd : '0;
    // set is applied after clear so a re-issue to the register being written back stays pending
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_pend <= '0;
        else r_pend <= ((r_pend & ~w_clr) | w_set) & ~NUM_REGS'(1);
    end
endmodule

// File: tb/tb_fu_issue_scoreboard.sv
// tb_fu_issue_scoreboard: directed, table-driven check of issue, hazards, arbitration, flush and reset.
module tb_fu_issue_scoreboard;
    import fu_sched_pkg::*;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;
    fu_issue_scoreboard_if bus();
    fu_issue_scoreboard dut (.CLK(clk), .nRST(nrst), .bus(bus));
    int n_chk = 0;
    int n_pass = 0;
    typedef struct {
        logic       iv;
        scalar_fu_t t;
        logic [4:0] rs1, rs2, rd;
        logic       wen, fl;
        logic [3:0] dn;
        logic       rdy;
        logic [3:0] st;
        logic       wbv;
        logic [3:0] gr;
        logic [4:0] wrd;
    } vec_t;
    vec_t vq[$];
    function automatic vec_t mk(logic iv, scalar_fu_t t, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic wen, logic fl, logic [3:0] dn, logic rdy, logic [3:0] st,
                                logic wbv, logic [3:0] gr, logic [4:0] wrd);
        vec_t v;
        v.iv = iv; v.t = t; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wen = wen; v.fl = fl; v.dn = dn;
        v.rdy = rdy; v.st = st; v.wbv = wbv; v.gr = gr; v.wrd = wrd;
        return v;
    endfunction
    task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    endtask
    task automatic drive(vec_t v);
        bus.issue_valid = v.iv;
        bus.sfu_type = v.t;
        bus.reg_rs1 = v.rs1;
        bus.reg_rs2 = v.rs2;
        bus.reg_rd = v.rd;
        bus.wen = v.wen;
        bus.flush = v.fl;
        bus.fu_done = v.dn;
    endtask
    task automatic check_out(int row, vec_t v);
        chk("issue_ready", row, 32'(bus.issue_ready), 32'(v.rdy));
        chk("fu_start", row, 32'(bus.fu_start), 32'(v.st));
        chk("wb_valid", row, 32'(bus.wb_valid), 32'(v.wbv));
        chk("wb_grant", row, 32'(bus.wb_grant), 32'(v.gr));
        chk("wb_rd", row, 32'(bus.wb_rd), 32'(v.wrd));
    endtask
    task automatic apply(int row, vec_t v);
        @(negedge clk);
        drive(v);
        #4;
        check_out(row, v);
    endtask
    initial begin
        // RAW stall on a 4-cycle MUL, cleared in the grant cycle
        vq.push_back(mk(1, SFU_MUL, 0, 0, 3, 1, 0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 3, 0, 8, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 3, 0, 8, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 3, 0, 8, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 3, 0, 8, 1, 0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 3, 0, 8, 1, 0, 4'b0000, 1, 4'b0001, 1, 4'b0010, 3));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'b0001, 8));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        // arbitration: ARITH and LSU finish together, LSU first
        vq.push_back(mk(1, SFU_ALU, 0, 0, 9, 1, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_LSU, 0, 0, 7, 1, 0, 4'b0000, 1, 4'b1000, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b1001, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_MUL, 9, 0, 10, 1, 0, 4'b0000, 0, 4'b0000, 1, 4'b1000, 7));
        vq.push_back(mk(1, SFU_MUL, 9, 0, 10, 1, 0, 4'b0000, 1, 4'b0010, 1, 4'b0001, 9));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'b0010, 10));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        // structural hazard on DIV
        vq.push_back(mk(1, SFU_DIV, 0, 0, 11, 1, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_DIV, 0, 0, 12, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_DIV, 0, 0, 12, 1, 0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_DIV, 0, 0, 12, 1, 0, 4'b0000, 0, 4'b0000, 1, 4'b0100, 11));
        vq.push_back(mk(1, SFU_DIV, 0, 0, 12, 1, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'b0100, 12));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        // x0 destination and a store: no pending bits, no write-back
        vq.push_back(mk(1, SFU_ALU, 0, 0, 0, 1, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_LSU, 0, 0, 13, 0, 0, 4'b0000, 1, 4'b1000, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b1001, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 13, 0, 14, 1, 0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 0));
        // WAW stall, then re-issue to x14 in its grant cycle (set beats clear)
        vq.push_back(mk(1, SFU_MUL, 0, 0, 14, 1, 0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_MUL, 0, 0, 14, 1, 0, 4'b0000, 1, 4'b0010, 1, 4'b0001, 14));
        vq.push_back(mk(1, SFU_ALU, 14, 0, 0, 0, 0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 14, 0, 0, 0, 0, 4'b0000, 1, 4'b0001, 1, 4'b0010, 14));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        // flush blocks only the current issue; in-flight MUL still writes back
        vq.push_back(mk(1, SFU_MUL, 0, 0, 6, 1, 0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 0, 0, 4, 1, 1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(1, SFU_ALU, 4, 0, 15, 1, 0, 4'b0010, 1, 4'b0001, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 1, 4'b0010, 6));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'b0001, 15));
        // fu_done on idle slots is ignored
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 0));
        vq.push_back(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        // outputs held at zero under reset even with a request presented
        drive(mk(1, SFU_ALU, 0, 0, 1, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        #3;
        check_out(-1, mk(1, SFU_ALU, 0, 0, 1, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        drive(mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        foreach (vq[i]) apply(i, vq[i]);
        // reset while DIV is busy with rd=5
        apply(100, mk(1, SFU_DIV, 0, 0, 5, 1, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 0));
        apply(101, mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        @(negedge clk);
        nrst = 1'b0;
        drive(mk(1, SFU_DIV, 0, 0, 5, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        #4;
        check_out(102, mk(1, SFU_DIV, 0, 0, 5, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        @(negedge clk);
        nrst = 1'b1;
        #4;
        check_out(103, mk(1, SFU_DIV, 0, 0, 5, 1, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 0));
        apply(104, mk(1, SFU_ALU, 5, 0, 16, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        apply(105, mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 0));
        apply(106, mk(1, SFU_ALU, 5, 0, 16, 1, 0, 4'b0000, 1, 4'b0001, 1, 4'b0100, 5));
        apply(107, mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0));
        apply(108, mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'b0001, 16));
        apply(109, mk(0, SFU_ALU, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
